// File: rtl/mem_responder.sv
// Memory-side responder: fixed-latency RAM access with RV32 byte/half/word
// load/store lanes, sign/zero extension and misalignment/illegal-width faults.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_res,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    logic [1:0]              r_state;
    logic [3:0]              r_cnt;
    logic [DEPTH_LOG2+1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [2:0]              r_funct3;
    logic                    r_op_write;
    logic [31:0]             r_rdata;
    logic                    r_err;
    logic [31:0]             r_mem [0:(2**DEPTH_LOG2)-1];

    logic                    w_commit;
    logic                    w_fault;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [31:0]             w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;
    logic [3:0]              w_wmask;
    logic [31:0]             w_wval;
    logic                    w_unused_addr;

    // Upper address bits alias the array; they are intentionally dropped.
    assign w_unused_addr = ^addr[31:DEPTH_LOG2+2];

    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[DEPTH_LOG2+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_half   = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    // funct3[2] selects zero extension for loads.
    always_comb begin
        w_load = 32'd0;
        case (r_funct3[1:0])
            2'b00: w_load = {{24{~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01: w_load = {{16{~r_funct3[2] & w_half[15]}}, w_half};
            2'b10: w_load = w_word;
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_fault = 1'b0;
        if (r_op_write) begin
            case (r_funct3)
                3'b000:  w_fault = 1'b0;
                3'b001:  w_fault = r_addr[0];
                3'b010:  w_fault = |r_addr[1:0];
                default: w_fault = 1'b1;
            endcase
        end else begin
            case (r_funct3)
                3'b000, 3'b100: w_fault = 1'b0;
                3'b001, 3'b101: w_fault = r_addr[0];
                3'b010:         w_fault = |r_addr[1:0];
                default:        w_fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_wmask = 4'b0000;
        w_wval  = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_wmask = 4'b0001 << r_addr[1:0];
                w_wval  = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wval  = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_wmask = 4'b1111;
                w_wval  = r_wdata;
            end
            default: w_wmask = 4'b0000;
        endcase
    end

    // RAM is not reset; reset only blocks a commit that would land with it.
    always_ff @(posedge clock) begin
        if (!reset && w_commit && r_op_write && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wval[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_funct3   <= 3'd0;
            r_op_write <= 1'b0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_write || mem_read) begin
                        r_addr     <= addr[DEPTH_LOG2+1:0];
                        r_wdata    <= wdata;
                        r_funct3   <= funct3;
                        r_op_write <= mem_write;
                        r_cnt      <= CNT_INIT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        r_err   <= w_fault;
                        if (!r_op_write) begin
                            r_rdata <= w_fault ? 32'd0 : w_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata   = r_rdata;
    assign mem_res = (r_state == S_RESP);
    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at LATENCY=5.
module tb_mem_responder;
    localparam int LAT_A = 2;
    localparam int LAT_B = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_read = 0, a_write = 0;
    logic [2:0]  a_f3 = 0;
    logic [31:0] a_addr = 0, a_wdata = 0;
    logic [31:0] a_rdata;
    logic        a_res, a_busy, a_err;

    logic        b_read = 0, b_write = 0;
    logic [2:0]  b_f3 = 0;
    logic [31:0] b_addr = 0, b_wdata = 0;
    logic [31:0] b_rdata;
    logic        b_res, b_busy, b_err;

    logic        cur_sel = 1'b0;
    logic [31:0] m_rdata;
    logic        m_res, m_busy, m_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_A)) u_a (
        .clock(clock), .reset(reset), .mem_read(a_read), .mem_write(a_write),
        .funct3(a_f3), .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata),
        .mem_res(a_res), .busy(a_busy), .err(a_err)
    );

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_B)) u_b (
        .clock(clock), .reset(reset), .mem_read(b_read), .mem_write(b_write),
        .funct3(b_f3), .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata),
        .mem_res(b_res), .busy(b_busy), .err(b_err)
    );

    assign m_rdata = cur_sel ? b_rdata : a_rdata;
    assign m_res   = cur_sel ? b_res   : a_res;
    assign m_busy  = cur_sel ? b_busy  : a_busy;
    assign m_err   = cur_sel ? b_err   : a_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (cur_sel) begin
            b_write = wr; b_read = rd; b_f3 = f3; b_addr = a; b_wdata = wd;
        end else begin
            a_write = wr; a_read = rd; a_f3 = f3; a_addr = a; a_wdata = wd;
        end
    endtask

    task automatic drop_req();
        a_write = 0; a_read = 0; b_write = 0; b_read = 0;
    endtask

    // One request: accept, measure edges to mem_res, check err/rdata, check release.
    task automatic do_req(input string tag, input logic wr, input logic rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rdata);
        int edges;
        int exp_lat;
        exp_lat = (cur_sel ? LAT_B : LAT_A) - 1;
        @(negedge clock);
        drive(wr, rd, f3, a, wd);
        @(posedge clock); #1;
        drop_req();
        check_eq({tag, "_busy"}, {31'd0, m_busy}, 32'd1);
        edges = 0;
        while (!m_res && edges < 20) begin
            @(posedge clock); #1;
            edges++;
        end
        check_eq({tag, "_lat"}, edges, exp_lat);
        check_eq({tag, "_err"}, {31'd0, m_err}, {31'd0, exp_err});
        check_eq({tag, "_rdata"}, m_rdata, exp_rdata);
        @(posedge clock); #1;
        check_eq({tag, "_res_off"}, {30'd0, m_res, m_busy}, 32'd0);
    endtask

    initial begin
        int pulses;

        #1;
        check_eq("rst_a", {a_rdata[31:0]}, 32'd0);
        check_eq("rst_a_flags", {29'd0, a_res, a_busy, a_err}, 32'd0);
        check_eq("rst_b_flags", {29'd0, b_res, b_busy, b_err}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;

        do_req("sw10",   1, 0, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        do_req("lw10",   0, 1, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        do_req("lb13",   0, 1, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFDE);
        do_req("lbu13",  0, 1, 3'b100, 32'h13, 32'h0,        0, 32'h000000DE);
        do_req("lh12",   0, 1, 3'b001, 32'h12, 32'h0,        0, 32'hFFFFDEAD);
        do_req("lhu10",  0, 1, 3'b101, 32'h10, 32'h0,        0, 32'h0000BEEF);
        do_req("sb11",   1, 0, 3'b000, 32'h11, 32'h55,       0, 32'h0000BEEF);
        do_req("lw10b",  0, 1, 3'b010, 32'h10, 32'h0,        0, 32'hDEAD55EF);
        do_req("sh12",   1, 0, 3'b001, 32'h12, 32'h1234,     0, 32'hDEAD55EF);
        do_req("lw10c",  0, 1, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF);
        do_req("lw11",   0, 1, 3'b010, 32'h11, 32'h0,        1, 32'h0);
        do_req("sh13",   1, 0, 3'b001, 32'h13, 32'hFFFF,     1, 32'h0);
        do_req("lw10d",  0, 1, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF);
        do_req("ld011",  0, 1, 3'b011, 32'h10, 32'h0,        1, 32'h0);
        do_req("st011",  1, 0, 3'b011, 32'h10, 32'hFFFFFFFF, 1, 32'h0);
        do_req("lw10e",  0, 1, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF);
        do_req("lwalias",0, 1, 3'b010, 32'h1010, 32'h0,      0, 32'h123455EF);
        do_req("sw40",   1, 0, 3'b010, 32'h40, 32'h0,        0, 32'h123455EF);
        do_req("sw20",   1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h123455EF);
        do_req("both",   1, 1, 3'b010, 32'h30, 32'hCAFEF00D, 0, 32'h123455EF);
        do_req("lw30",   0, 1, 3'b010, 32'h30, 32'h0,        0, 32'hCAFEF00D);

        // Request raised while busy (WAIT and RESP) with changed inputs: ignored.
        @(negedge clock);
        drive(0, 1, 3'b010, 32'h10, 32'h0);
        @(posedge clock); #1;
        drive(1, 0, 3'b000, 32'h40, 32'h11111111);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            if (a_res) pulses++;
        end
        drop_req();
        check_eq("ign_rdata", a_rdata, 32'h123455EF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (a_res) pulses++;
        end
        check_eq("ign_pulses", pulses, 1);
        check_eq("ign_busy", {31'd0, a_busy}, 32'd0);
        do_req("lw40",   0, 1, 3'b010, 32'h40, 32'h0,        0, 32'h0);
        do_req("lw30b",  0, 1, 3'b010, 32'h30, 32'h0,        0, 32'hCAFEF00D);

        // Reset during WAIT of a store: aborted, no pulse, no write.
        @(negedge clock);
        drive(1, 0, 3'b010, 32'h20, 32'hAAAAAAAA);
        @(posedge clock); #1;
        check_eq("abort_busy", {31'd0, a_busy}, 32'd1);
        reset = 1;
        drop_req();
        #1;
        check_eq("abort_rdata", a_rdata, 32'd0);
        check_eq("abort_flags", {29'd0, a_res, a_busy, a_err}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            if (a_res) pulses++;
        end
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (a_res) pulses++;
        end
        check_eq("abort_pulses", pulses, 0);
        do_req("lw20",   0, 1, 3'b010, 32'h20, 32'h0,        0, 32'h0);

        // LATENCY=5 instance.
        cur_sel = 1'b1;
        do_req("b_sw8",  1, 0, 3'b010, 32'h8, 32'h80FF0102,  0, 32'h0);
        do_req("b_lw8",  0, 1, 3'b010, 32'h8, 32'h0,         0, 32'h80FF0102);
        do_req("b_lbb",  0, 1, 3'b000, 32'hB, 32'h0,         0, 32'hFFFFFF80);
        do_req("b_lhua", 0, 1, 3'b101, 32'hA, 32'h0,         0, 32'h000080FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x00000001 expected 0x00000000");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle core's control unit. It accepts the unit's mem_read/mem_write requests, services them against an internal word-organised RAM after a fixed configurable latency, and pulses mem_res to mark completion. It implements RV32 load/store width selection (byte, halfword, word), sign/zero extension, byte-lane writes and misalignment detection.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; address bits [DEPTH_LOG2+1:2] index the array.
LATENCY, 2, clock edges from request acceptance to the mem_res cycle; legal range 2..15.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
mem_read  input  1  read request, level, sampled in IDLE
mem_write  input  1  write request, level, sampled in IDLE; priority over mem_read
funct3  input  3  access width/sign (RV32 load/store encoding)
addr  input  32  byte address
wdata  input  32  store data, lane-aligned from bit 0
rdata  output  32  extended load result
mem_res  output  1  one-cycle completion pulse
busy  output  1  request in flight
err  output  1  access fault, valid with mem_res

Behaviour:
- Reset is asynchronous and active-high on reset; the clock is clock. Reset forces state=IDLE, cnt=0, mem_res=0, busy=0, err=0, rdata=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: at a rising edge with mem_write=1 or mem_read=1, latch addr, wdata, funct3 and op, where op=write if mem_write=1, else read. Load cnt=LATENCY-2 and go to WAIT. If neither request is high, stay in IDLE.
  - WAIT: if cnt==0, go to RESP at the next edge and perform the access on that same edge. Otherwise decrement cnt.
  - RESP: mem_res=1 and err is valid for exactly one cycle, then go to IDLE.
- Timing: with accept edge k, mem_res is high from edge k+LATENCY-1 to edge k+LATENCY. The next request can be accepted at edge k+LATENCY+1 at the earliest.
- busy=1 from the accept edge until the RESP cycle ends, inclusive. Requests arriving while not in IDLE are ignored; there is no queue. A request still high when the FSM returns to IDLE is accepted again.
- Only latched values are used after acceptance. Input changes during WAIT have no effect.
- Reads (value registered on the edge entering RESP):
  - 000 LB: byte selected by addr[1:0], sign-extended.
  - 100 LBU: the same byte, zero-extended.
  - 001 LH: halfword selected by addr[1], sign-extended.
  - 101 LHU: the same halfword, zero-extended.
  - 010 LW: full word.
- Writes (committed on the edge entering RESP):
  - 000 SB: wdata[7:0] into byte lane addr[1:0].
  - 001 SH: wdata[15:0] into halfword lane addr[1].
  - 010 SW: full word.
  - Unselected lanes keep their contents.
- Faults: any of the following sets err=1 in RESP.
  - Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
  - On fault there is no RAM write, rdata=0, and mem_res still pulses.
- Address wrap: bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
- rdata holds its value until the next read completes. A write leaves rdata unchanged.
- Reset mid-operation: the transaction is aborted. If reset is asserted before the commit edge, no write occurs. mem_res never pulses for the aborted request.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 (LATENCY=2) -> each mem_res high exactly in the cycle after edge k+1; rdata=0xDEADBEEF, err=0.
- After the above, LB 0x13 -> rdata=0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 wdata=0x55, then LW 0x10 -> 0xDEAD55EF. SH 0x12 wdata=0x1234 -> LW 0x10 reads 0x123455EF.
- LW 0x11 and SH 0x13 -> err=1 with mem_res; a following LW 0x10 shows the word unchanged and the faulting read returns rdata=0. A load with funct3=011 also gives err=1.
- Overlap handling: mem_read and mem_write both high -> write performed. New request pulsed while busy -> ignored, no second mem_res. With LATENCY=5, mem_res appears 4 edges after acceptance.
- Reset asserted during WAIT of SW 0x20 wdata=0xAAAAAAAA (previous contents 0) -> outputs are 0 immediately, no mem_res pulse, and a subsequent LW 0x20 returns 0.
